// File: rtl/fifo_arb_pkg.sv
// Shared types and helpers for the FIFO command-port arbiter.
package fifo_arb_pkg;

    // Arbiter FSM: normal request service or FIFO drain.
    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_e;

    // Operation class, used to remember which side was served last.
    typedef enum logic {
        CLS_RD = 1'b0,
        CLS_WR = 1'b1
    } cls_e;

    // Width of a round-robin pointer over n requesters (at least one bit).
    function automatic int unsigned RR_W(input int unsigned n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: grants the first requester at or after ptr.
module rr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned N = 4
) (
    input  logic [N-1:0]       req,
    input  logic [RR_W(N)-1:0] ptr,
    output logic [N-1:0]       gnt
);

    logic found;

    // Scan offsets from ptr in priority order; the first set request wins.
    // Each candidate is matched by its wrapped distance from ptr, which keeps
    // every bit select on a loop constant.
    always_comb begin
        gnt   = '0;
        found = 1'b0;
        for (int unsigned off = 0; off < N; off++) begin
            for (int unsigned i = 0; i < N; i++) begin
                if (!found && req[i] &&
                    ((i == 32'(ptr) + off) || (i + N == 32'(ptr) + off))) begin
                    gnt[i] = 1'b1;
                    found  = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/fifo_port_arbiter.sv
// Shares one FIFO en/rw command port between NUM_WR writers and one reader,
// returns read data with a valid strobe and can drain the FIFO on request.
module fifo_port_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_WR       = 4,
    parameter int unsigned DATA_WIDTH   = 4,
    parameter bit          FALL_THROUGH = 1'b1
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic [NUM_WR-1:0]            wr_req,
    input  logic [NUM_WR*DATA_WIDTH-1:0] wr_data,
    output logic [NUM_WR-1:0]            wr_gnt,
    input  logic                         rd_req,
    output logic                         rd_gnt,
    output logic                         rd_valid,
    output logic [DATA_WIDTH-1:0]        rd_data,
    input  logic                         flush,
    output logic                         flush_busy,
    output logic                         flush_done,
    output logic                         fifo_en,
    output logic                         fifo_rw,
    output logic [DATA_WIDTH-1:0]        fifo_in,
    input  logic [DATA_WIDTH-1:0]        fifo_out,
    input  logic                         fifo_empty,
    input  logic                         fifo_full
);

    localparam int unsigned PW = RR_W(NUM_WR);

    state_e            state_q, state_d;
    cls_e              prio_q, prio_d;
    logic [PW-1:0]     rr_ptr_q, rr_ptr_d;

    logic [NUM_WR-1:0]     arb_gnt;
    logic [DATA_WIDTH-1:0] sel_data;
    logic [PW-1:0]         next_ptr;
    logic                  wr_elig, rd_elig;
    logic                  take_wr, take_rd;

    rr_arbiter #(
        .N(NUM_WR)
    ) u_rr (
        .req(wr_req),
        .ptr(rr_ptr_q),
        .gnt(arb_gnt)
    );

    // Write data and the pointer successor for whichever requester the RR picker chose.
    always_comb begin
        sel_data = '0;
        next_ptr = '0;
        for (int unsigned i = 0; i < NUM_WR; i++) begin
            if (arb_gnt[i]) begin
                sel_data = sel_data | wr_data[i*DATA_WIDTH +: DATA_WIDTH];
                next_ptr = (i == NUM_WR - 1) ? '0 : PW'(i + 1);
            end
        end
    end

    // Class arbitration, FIFO command generation and FSM next state.
    always_comb begin
        state_d    = state_q;
        prio_d     = prio_q;
        rr_ptr_d   = rr_ptr_q;
        wr_gnt     = '0;
        rd_gnt     = 1'b0;
        fifo_en    = 1'b0;
        fifo_rw    = 1'b0;
        fifo_in    = '0;
        flush_busy = 1'b0;
        flush_done = 1'b0;
        take_wr    = 1'b0;
        take_rd    = 1'b0;
        wr_elig    = (|wr_req) && !fifo_full;
        rd_elig    = rd_req && !fifo_empty;

        unique case (state_q)
            ST_RUN: begin
                if (wr_elig && (!rd_elig || prio_q == CLS_RD)) begin
                    take_wr = 1'b1;
                end else if (rd_elig) begin
                    take_rd = 1'b1;
                end

                if (take_wr) begin
                    wr_gnt   = arb_gnt;
                    fifo_en  = 1'b1;
                    fifo_rw  = 1'b1;
                    fifo_in  = sel_data;
                    prio_d   = CLS_WR;
                    rr_ptr_d = next_ptr;
                end else if (take_rd) begin
                    rd_gnt   = 1'b1;
                    fifo_en  = 1'b1;
                    prio_d   = CLS_RD;
                end

                if (flush) begin
                    state_d = ST_FLUSH;
                end
            end

            ST_FLUSH: begin
                flush_busy = 1'b1;
                if (!fifo_empty) begin
                    fifo_en = 1'b1;
                end else begin
                    flush_done = 1'b1;
                    state_d    = ST_RUN;
                end
            end

            default: begin
                state_d = ST_RUN;
            end
        endcase

        // Commands are combinational from requests, so they must be gated
        // explicitly while reset is held.
        if (rst) begin
            wr_gnt  = '0;
            rd_gnt  = 1'b0;
            fifo_en = 1'b0;
            fifo_rw = 1'b0;
            fifo_in = '0;
        end
    end

    // FSM, class priority and round-robin pointer registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= ST_RUN;
            prio_q   <= CLS_RD;
            rr_ptr_q <= '0;
        end else begin
            state_q  <= state_d;
            prio_q   <= prio_d;
            rr_ptr_q <= rr_ptr_d;
        end
    end

    generate
        if (FALL_THROUGH) begin : g_fall_through
            // FIFO head is already visible, so data returns in the grant cycle.
            always_comb begin
                rd_valid = rd_gnt;
                rd_data  = rst ? '0 : fifo_out;
            end
        end else begin : g_registered
            logic                  rd_valid_q;
            logic [DATA_WIDTH-1:0] rd_data_q;

            // FIFO output updates on the read edge; track the strobe and hold the last word.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    rd_valid_q <= 1'b0;
                    rd_data_q  <= '0;
                end else begin
                    rd_valid_q <= rd_gnt;
                    if (rd_valid_q) begin
                        rd_data_q <= fifo_out;
                    end
                end
            end

            // Present live FIFO data in the valid cycle, the held word otherwise.
            always_comb begin
                rd_valid = rd_valid_q;
                rd_data  = rd_valid_q ? fifo_out : rd_data_q;
            end
        end
    endgenerate

endmodule

// File: tb/tb_fifo_port_arbiter.sv
// Bench for fifo_port_arbiter: a fall-through instance (A) driven by directed
// and random stimulus against a queue-based model, plus a registered-output
// instance (B) for read latency.
module tb_fifo_port_arbiter;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [3:0] wg;
        logic       rg;
        logic       en;
        logic       rw;
        logic [3:0] din;
        logic       busy;
        logic       done;
        logic [3:0] rdat;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    logic fclr;

    // Instance A (fall-through)
    logic [3:0]  wr_req_a, wr_gnt_a;
    logic [15:0] wr_data_a;
    logic        rd_req_a, rd_gnt_a, rd_valid_a, flush_a, flush_busy_a, flush_done_a;
    logic [3:0]  rd_data_a, fifo_in_a, fifo_out_a;
    logic        fifo_en_a, fifo_rw_a, fifo_empty_a, fifo_full_a;

    // Instance B (registered output)
    logic [3:0]  wr_req_b, wr_gnt_b;
    logic [15:0] wr_data_b;
    logic        rd_req_b, rd_gnt_b, rd_valid_b, flush_b, flush_busy_b, flush_done_b;
    logic [3:0]  rd_data_b, fifo_in_b, fifo_out_b;
    logic        fifo_en_b, fifo_rw_b, fifo_empty_b, fifo_full_b;

    int unsigned nchk = 0;
    int unsigned nerr = 0;

    // Reference model state
    int unsigned m_ptr;
    bit          m_last_wr;
    bit          m_flush;
    logic [3:0]  m_q[$];
    logic [3:0]  sweep_d[4];

    always #5 clk = ~clk;

    fifo_port_arbiter #(.NUM_WR(4), .DATA_WIDTH(4), .FALL_THROUGH(1'b1)) dut_a (
        .clk(clk), .rst(rst),
        .wr_req(wr_req_a), .wr_data(wr_data_a), .wr_gnt(wr_gnt_a),
        .rd_req(rd_req_a), .rd_gnt(rd_gnt_a), .rd_valid(rd_valid_a), .rd_data(rd_data_a),
        .flush(flush_a), .flush_busy(flush_busy_a), .flush_done(flush_done_a),
        .fifo_en(fifo_en_a), .fifo_rw(fifo_rw_a), .fifo_in(fifo_in_a), .fifo_out(fifo_out_a),
        .fifo_empty(fifo_empty_a), .fifo_full(fifo_full_a)
    );

    fifo_port_arbiter #(.NUM_WR(4), .DATA_WIDTH(4), .FALL_THROUGH(1'b0)) dut_b (
        .clk(clk), .rst(rst),
        .wr_req(wr_req_b), .wr_data(wr_data_b), .wr_gnt(wr_gnt_b),
        .rd_req(rd_req_b), .rd_gnt(rd_gnt_b), .rd_valid(rd_valid_b), .rd_data(rd_data_b),
        .flush(flush_b), .flush_busy(flush_busy_b), .flush_done(flush_done_b),
        .fifo_en(fifo_en_b), .fifo_rw(fifo_rw_b), .fifo_in(fifo_in_b), .fifo_out(fifo_out_b),
        .fifo_empty(fifo_empty_b), .fifo_full(fifo_full_b)
    );

    // FIFO A: depth 4, head visible combinationally
    logic [3:0] mem_a [DEPTH];
    logic [1:0] rp_a, wp_a;
    logic [2:0] cnt_a;
    logic       push_a, pop_a;
    assign push_a       = fifo_en_a && fifo_rw_a && (cnt_a < 3'(DEPTH));
    assign pop_a        = fifo_en_a && !fifo_rw_a && (cnt_a != 3'd0);
    assign fifo_empty_a = (cnt_a == 3'd0);
    assign fifo_full_a  = (cnt_a == 3'(DEPTH));
    assign fifo_out_a   = mem_a[rp_a];
    always @(posedge clk) begin
        if (fclr) begin
            rp_a <= '0; wp_a <= '0; cnt_a <= '0;
        end else begin
            if (push_a) begin mem_a[wp_a] <= fifo_in_a; wp_a <= wp_a + 2'd1; end
            if (pop_a) rp_a <= rp_a + 2'd1;
            cnt_a <= cnt_a + {2'b0, push_a} - {2'b0, pop_a};
        end
    end

    // FIFO B: depth 4, output registered on read
    logic [3:0] mem_b [DEPTH];
    logic [1:0] rp_b, wp_b;
    logic [2:0] cnt_b;
    logic       push_b, pop_b;
    assign push_b       = fifo_en_b && fifo_rw_b && (cnt_b < 3'(DEPTH));
    assign pop_b        = fifo_en_b && !fifo_rw_b && (cnt_b != 3'd0);
    assign fifo_empty_b = (cnt_b == 3'd0);
    assign fifo_full_b  = (cnt_b == 3'(DEPTH));
    always @(posedge clk) begin
        if (fclr) begin
            rp_b <= '0; wp_b <= '0; cnt_b <= '0; fifo_out_b <= '0;
        end else begin
            if (push_b) begin mem_b[wp_b] <= fifo_in_b; wp_b <= wp_b + 2'd1; end
            if (pop_b) begin fifo_out_b <= mem_b[rp_b]; rp_b <= rp_b + 2'd1; end
            cnt_b <= cnt_b + {2'b0, push_b} - {2'b0, pop_b};
        end
    end

    // Expected instance-A outputs for the current inputs and model state.
    function automatic exp_t predict();
        exp_t        e;
        bit          wr_ok, rd_ok, hit;
        int unsigned k;
        e   = '0;
        hit = 1'b0;
        if (rst) return e;
        if (m_flush) begin
            e.busy = 1'b1;
            if (m_q.size() != 0) e.en = 1'b1;
            else e.done = 1'b1;
            return e;
        end
        wr_ok = (wr_req_a != 4'b0) && (m_q.size() < DEPTH);
        rd_ok = rd_req_a && (m_q.size() > 0);
        if (wr_ok && (!rd_ok || !m_last_wr)) begin
            for (int unsigned off = 0; off < 4; off++) begin
                k = (m_ptr + off) % 4;
                if (!hit && wr_req_a[k]) begin
                    hit     = 1'b1;
                    e.wg[k] = 1'b1;
                    e.din   = wr_data_a[k*4 +: 4];
                end
            end
            e.en = 1'b1;
            e.rw = 1'b1;
        end else if (rd_ok) begin
            e.rg   = 1'b1;
            e.en   = 1'b1;
            e.rdat = m_q[0];
        end
        return e;
    endfunction

    // Apply the effect of the coming clock edge to the model.
    task automatic model_advance();
        exp_t e;
        e = predict();
        if (rst) begin
            m_ptr = 0; m_last_wr = 1'b0; m_flush = 1'b0;
            return;
        end
        if (m_flush) begin
            if (m_q.size() != 0) void'(m_q.pop_front());
            else m_flush = 1'b0;
        end else begin
            if (e.en && e.rw) begin
                m_q.push_back(e.din);
                for (int unsigned k = 0; k < 4; k++)
                    if (e.wg[k]) m_ptr = (k + 1) % 4;
                m_last_wr = 1'b1;
            end else if (e.rg) begin
                void'(m_q.pop_front());
                m_last_wr = 1'b0;
            end
            if (flush_a) m_flush = 1'b1;
        end
    endtask

    task automatic step();
        model_advance();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_inputs();
        wr_req_a = '0; wr_data_a = '0; rd_req_a = 1'b0; flush_a = 1'b0;
        wr_req_b = '0; wr_data_b = '0; rd_req_b = 1'b0; flush_b = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; fclr = 1'b1;
        wr_req_a = 4'b1111; rd_req_a = 1'b1; flush_a = 1'b1;
        wr_req_b = 4'b1111; rd_req_b = 1'b1;
        #3;
        nchk++; if (wr_gnt_a !== 4'b0) begin nerr++; $display("FAIL reset_wr_gnt: got %b want 0000", wr_gnt_a); end
        nchk++; if (fifo_en_a !== 1'b0 || rd_gnt_a !== 1'b0) begin nerr++; $display("FAIL reset_en: en=%b rd_gnt=%b want 0 0", fifo_en_a, rd_gnt_a); end
        nchk++; if (flush_busy_a !== 1'b0 || flush_done_a !== 1'b0) begin nerr++; $display("FAIL reset_flush: busy=%b done=%b want 0 0", flush_busy_a, flush_done_a); end
        nchk++; if (rd_valid_a !== 1'b0 || rd_valid_b !== 1'b0) begin nerr++; $display("FAIL reset_valid: a=%b b=%b want 0 0", rd_valid_a, rd_valid_b); end
        nchk++; if (rd_data_b !== 4'h0 || rd_data_a !== 4'h0) begin nerr++; $display("FAIL reset_rd_data: a=%h b=%h want 0 0", rd_data_a, rd_data_b); end
        nchk++; if (wr_gnt_b !== 4'b0 || fifo_en_b !== 1'b0) begin nerr++; $display("FAIL reset_b_cmd: gnt=%b en=%b want 0000 0", wr_gnt_b, fifo_en_b); end
        m_q.delete();
        step();
        step();
        rst = 1'b0; fclr = 1'b0;
        clear_inputs();
    endtask

    task automatic test_ft0_latency();
        wr_req_b = 4'b0001; wr_data_b = 16'h0005;
        #3;
        nchk++; if (wr_gnt_b !== 4'b0001 || fifo_in_b !== 4'h5) begin nerr++; $display("FAIL ft0_write: gnt=%b in=%h want 0001 5", wr_gnt_b, fifo_in_b); end
        step();
        wr_req_b = '0; wr_data_b = '0; rd_req_b = 1'b1;
        #3;
        nchk++; if (rd_gnt_b !== 1'b1 || rd_valid_b !== 1'b0) begin nerr++; $display("FAIL ft0_grant: rd_gnt=%b valid=%b want 1 0", rd_gnt_b, rd_valid_b); end
        step();
        rd_req_b = 1'b0;
        #3;
        nchk++; if (rd_valid_b !== 1'b1 || rd_data_b !== 4'h5) begin nerr++; $display("FAIL ft0_valid: valid=%b data=%h want 1 5", rd_valid_b, rd_data_b); end
        step();
        #3;
        nchk++; if (rd_valid_b !== 1'b0 || rd_data_b !== 4'h5) begin nerr++; $display("FAIL ft0_hold: valid=%b data=%h want 0 5", rd_valid_b, rd_data_b); end
        step();
    endtask

    task automatic test_rr_sweep();
        logic [15:0] d;
        wr_req_a = 4'b1111;
        for (int c = 0; c < 4; c++) begin
            wr_data_a = 16'($urandom);
            d = wr_data_a;
            sweep_d[c] = d[c*4 +: 4];
            #3;
            nchk++; if (wr_gnt_a !== 4'(1 << c)) begin nerr++; $display("FAIL rr_gnt[%0d]: got %b want %b", c, wr_gnt_a, 4'(1 << c)); end
            nchk++; if (fifo_in_a !== sweep_d[c] || fifo_en_a !== 1'b1 || fifo_rw_a !== 1'b1) begin nerr++; $display("FAIL rr_cmd[%0d]: in=%h en=%b rw=%b want %h 1 1", c, fifo_in_a, fifo_en_a, fifo_rw_a, sweep_d[c]); end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_full_block();
        wr_req_a = 4'b0010; wr_data_a = 16'hABCD;
        #3;
        nchk++; if (wr_gnt_a !== 4'b0 || fifo_en_a !== 1'b0) begin nerr++; $display("FAIL full_block: gnt=%b en=%b want 0000 0", wr_gnt_a, fifo_en_a); end
        step();
        rd_req_a = 1'b1;
        #3;
        nchk++; if (rd_gnt_a !== 1'b1 || wr_gnt_a !== 4'b0 || fifo_rw_a !== 1'b0) begin nerr++; $display("FAIL full_read: rd_gnt=%b wr_gnt=%b rw=%b want 1 0000 0", rd_gnt_a, wr_gnt_a, fifo_rw_a); end
        nchk++; if (rd_valid_a !== 1'b1 || rd_data_a !== sweep_d[0]) begin nerr++; $display("FAIL full_rdata: valid=%b data=%h want 1 %h", rd_valid_a, rd_data_a, sweep_d[0]); end
        step();
        wr_req_a = '0;
        #3;
        nchk++; if (rd_gnt_a !== 1'b1 || rd_data_a !== sweep_d[1]) begin nerr++; $display("FAIL second_read: rd_gnt=%b data=%h want 1 %h", rd_gnt_a, rd_data_a, sweep_d[1]); end
        step();
        clear_inputs();
    endtask

    task automatic test_alternate();
        wr_req_a = 4'b0001; rd_req_a = 1'b1;
        for (int c = 0; c < 4; c++) begin
            exp_t e;
            wr_data_a = 16'($urandom);
            e = predict();
            #3;
            nchk++;
            if ((c % 2 == 0) ? (wr_gnt_a !== 4'b0001 || rd_gnt_a !== 1'b0)
                             : (wr_gnt_a !== 4'b0000 || rd_gnt_a !== 1'b1 || rd_data_a !== e.rdat)) begin
                nerr++;
                $display("FAIL alternate[%0d]: wr_gnt=%b rd_gnt=%b data=%h want %s data %h", c, wr_gnt_a, rd_gnt_a, rd_data_a, (c % 2 == 0) ? "write" : "read", e.rdat);
            end
            step();
        end
        clear_inputs();
    endtask

    task automatic test_flush();
        int unsigned busy_n, read_n, done_n;
        bit          exited;
        busy_n = 0; read_n = 0; done_n = 0; exited = 1'b0;
        wr_req_a = 4'b0001; wr_data_a = 16'h0007;
        step();
        nchk++; if (m_q.size() != 3 || cnt_a !== 3'd3) begin nerr++; $display("FAIL flush_setup: fifo count=%0d want 3", cnt_a); end
        clear_inputs();
        flush_a = 1'b1;
        #3;
        nchk++; if (flush_busy_a !== 1'b0) begin nerr++; $display("FAIL flush_start_busy: got %b want 0", flush_busy_a); end
        step();
        flush_a = 1'b0;
        for (int c = 0; c < 8 && !exited; c++) begin
            wr_req_a = 4'b1111; rd_req_a = 1'b1; wr_data_a = 16'($urandom);
            flush_a = (c == 1);
            #3;
            if (!flush_busy_a) begin
                exited = 1'b1;
                nchk++; if (fifo_empty_a !== 1'b1 || wr_gnt_a !== 4'b0010) begin nerr++; $display("FAIL flush_resume: empty=%b wr_gnt=%b want 1 0010", fifo_empty_a, wr_gnt_a); end
            end else begin
                busy_n++;
                if (fifo_en_a && !fifo_rw_a) read_n++;
                if (flush_done_a) done_n++;
                nchk++; if (wr_gnt_a !== 4'b0 || rd_gnt_a !== 1'b0 || rd_valid_a !== 1'b0) begin nerr++; $display("FAIL flush_quiet[%0d]: wr_gnt=%b rd_gnt=%b valid=%b want 0000 0 0", c, wr_gnt_a, rd_gnt_a, rd_valid_a); end
            end
            step();
        end
        nchk++; if (!exited) begin nerr++; $display("FAIL flush_timeout: busy still %b after 8 cycles want 0", flush_busy_a); end
        nchk++; if (busy_n != 4 || read_n != 3 || done_n != 1) begin nerr++; $display("FAIL flush_counts: busy=%0d reads=%0d done=%0d want 4 3 1", busy_n, read_n, done_n); end
        clear_inputs();
    endtask

    task automatic test_reset_mid_flush();
        wr_req_a = 4'b0001; wr_data_a = 16'h0003;
        step();
        step();
        clear_inputs();
        flush_a = 1'b1;
        step();
        flush_a = 1'b0;
        #3;
        nchk++; if (flush_busy_a !== 1'b1 || fifo_en_a !== 1'b1) begin nerr++; $display("FAIL midflush_first: busy=%b en=%b want 1 1", flush_busy_a, fifo_en_a); end
        step();
        rst = 1'b1; wr_req_a = 4'b1111; rd_req_a = 1'b1;
        #3;
        nchk++; if (flush_busy_a !== 1'b0 || fifo_en_a !== 1'b0 || flush_done_a !== 1'b0 || wr_gnt_a !== 4'b0) begin nerr++; $display("FAIL midflush_rst: busy=%b en=%b done=%b gnt=%b want 0 0 0 0000", flush_busy_a, fifo_en_a, flush_done_a, wr_gnt_a); end
        step();
        rst = 1'b0; wr_data_a = 16'h4321;
        #3;
        nchk++; if (wr_gnt_a !== 4'b0001 || rd_gnt_a !== 1'b0 || flush_busy_a !== 1'b0 || flush_done_a !== 1'b0) begin nerr++; $display("FAIL midflush_after: wr_gnt=%b rd_gnt=%b busy=%b done=%b want 0001 0 0 0", wr_gnt_a, rd_gnt_a, flush_busy_a, flush_done_a); end
        step();
        clear_inputs();
    endtask

    task automatic test_random();
        for (int c = 0; c < 300; c++) begin
            exp_t e;
            wr_req_a  = 4'($urandom);
            wr_data_a = 16'($urandom);
            rd_req_a  = ($urandom_range(2, 0) == 0);
            flush_a   = ($urandom_range(39, 0) == 0);
            e = predict();
            #3;
            nchk++;
            if ({wr_gnt_a, rd_gnt_a, fifo_en_a, fifo_rw_a, fifo_in_a} !== {e.wg, e.rg, e.en, e.rw, e.din}) begin
                nerr++;
                $display("FAIL rand_cmd[%0d]: gnt=%b rd=%b en=%b rw=%b in=%h want %b %b %b %b %h", c, wr_gnt_a, rd_gnt_a, fifo_en_a, fifo_rw_a, fifo_in_a, e.wg, e.rg, e.en, e.rw, e.din);
            end
            nchk++;
            if (flush_busy_a !== e.busy || flush_done_a !== e.done || rd_valid_a !== e.rg || (e.rg && rd_data_a !== e.rdat)) begin
                nerr++;
                $display("FAIL rand_status[%0d]: busy=%b done=%b valid=%b data=%h want %b %b %b %h", c, flush_busy_a, flush_done_a, rd_valid_a, rd_data_a, e.busy, e.done, e.rg, e.rdat);
            end
            step();
        end
        clear_inputs();
    endtask

    initial begin
        m_ptr = 0; m_last_wr = 1'b0; m_flush = 1'b0;
        rst = 1'b1; fclr = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;
        test_reset();
        test_ft0_latency();
        test_rr_sweep();
        test_full_block();
        test_alternate();
        test_flush();
        test_reset_mid_flush();
        test_random();
        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation still running at %0t want finished", $time);
        $fatal(1);
    end

endmodule

// File: doc/fifo_port_arbiter.md
# fifo_port_arbiter

Shares the single command port of a synchronous FIFO (`en`/`rw` style, with `empty`/`full` flags) between NUM_WR write requesters and one read requester. Each cycle it picks at most one operation and drives the FIFO command port. It also returns read data with a valid strobe and provides a flush sequence that drains the FIFO. It sits directly between the producer/consumer clients and the FIFO instance.

## Interface
- NUM_WR, default 4: number of write requesters, 2..16.
- DATA_WIDTH, default 4: must equal the FIFO data width.
- FALL_THROUGH, default 1: must match the FIFO's output mode.
  - 1: FIFO data is combinational from the head.
  - 0: FIFO data is registered on the read.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- wr_req  in  NUM_WR  per-requester write request; level, held until granted.
- wr_data  in  NUM_WR*DATA_WIDTH  packed write data; requester i at bits [i*DATA_WIDTH +: DATA_WIDTH].
- wr_gnt  out  NUM_WR  one-hot; pulses in the cycle the write is issued to the FIFO.
- rd_req  in  1  read request; level.
- rd_gnt  out  1  pulses in the cycle the read is issued.
- rd_valid  out  1  rd_data is valid this cycle.
- rd_data  out  DATA_WIDTH  read data.
- flush  in  1  pulse; starts a drain of the FIFO.
- flush_busy  out  1  high while draining.
- flush_done  out  1  one-cycle pulse when the drain completes.
- fifo_en, fifo_rw  out  1 each  FIFO command; rw=1 is write.
- fifo_in  out  DATA_WIDTH  FIFO write data.
- fifo_out  in  DATA_WIDTH  FIFO read data.
- fifo_empty, fifo_full  in  1 each  FIFO flags.

## Operation
FSM states: RUN and FLUSH.

RUN:
- A write is eligible when any wr_req is set and fifo_full=0.
- A read is eligible when rd_req=1 and fifo_empty=0.
- Only one eligible class: it is granted.
- Both classes eligible: the class not served last wins. The prio register records the last-served class; it resets to "read served last", so the write wins first.
- Write selection is round-robin over wr_req, starting at rr_ptr. After a write grant to requester k, rr_ptr becomes (k+1) mod NUM_WR.
- On a grant:
  - fifo_en=1.
  - fifo_rw=1 for a write, 0 for a read.
  - fifo_in = wr_data of the granted requester.
  - Exactly one grant bit is set.
- No grant: fifo_en=0, fifo_rw=0, fifo_in=0.
- flush=1 in RUN moves to FLUSH at the next edge. Any grant in that same cycle still completes.

FLUSH:
- All wr_gnt and rd_gnt are 0; requests are ignored.
- fifo_en=1 and fifo_rw=0 whenever fifo_empty=0. Drained data is discarded: rd_valid stays 0 for flush reads.
- When fifo_empty=1, pulse flush_done, then return to RUN at the next edge.
- flush asserted while already in FLUSH is ignored.

Read data:
- FALL_THROUGH=1: rd_data = fifo_out and rd_valid = rd_gnt, in the same cycle.
- FALL_THROUGH=0: rd_valid is registered rd_gnt, one cycle later, with rd_data = fifo_out. Outside valid cycles rd_data is held at its last value.

## Timing
- Grants and FIFO commands are combinational from the inputs and the registered state (rr_ptr, prio, FSM). Zero cycles from request to grant.
- Full/empty are sampled in the grant cycle. A write is never granted when full; a read is never granted when empty.
- Reset values:
  - Registers: FSM=RUN, rr_ptr=0, prio=read-last.
  - Outputs: rd_valid=0, rd_data=0, flush_busy=0, flush_done=0.
  - While rst=1, all grants and fifo_en are forced to 0.
- Reset mid-flush: return to RUN immediately; no flush_done.
- flush_busy=1 exactly while FSM=FLUSH. flush_done is asserted in the last FLUSH cycle.
- A requester whose wr_req drops before it is granted loses its turn; no state is kept for it.

## Structure
- Package fifo_arb_pkg holds:
  - the FSM state enum (ST_RUN, ST_FLUSH);
  - the class enum (CLS_RD, CLS_WR);
  - a clog2-based RR_W constant function.
- Sub-module rr_arbiter (parameter N) provides:
  - inputs req[N] and ptr;
  - output one-hot gnt, computed combinationally;
  - gnt = 0 when req = 0.
- The top level holds the FSM, prio, rr_ptr and the read-data pipeline.

## Test plan
- NUM_WR=4, wr_req=4'b1111 with empty FIFO, 4 cycles → wr_gnt sequence 0001, 0010, 0100, 1000; fifo_in tracks each requester's data.
- wr_req=4'b0001 and rd_req=1 with FIFO holding 2 entries → grants alternate write, read, write, read; first grant is the write.
- FIFO full, wr_req=4'b0010, rd_req=0 → no wr_gnt, fifo_en=0. Then rd_req=1 → rd_gnt in the same cycle.
- FALL_THROUGH=0: write 0x5, then read → rd_gnt in cycle n, rd_valid=1 with rd_data=0x5 in cycle n+1.
- FIFO holds 3 entries, pulse flush → flush_busy for 4 cycles, 3 reads issued, rd_valid stays 0. flush_done pulses, then fifo_empty=1 and RUN resumes; requests during flush get no grant.
- Assert rst during the second flush cycle → flush_busy=0, fifo_en=0, no flush_done; rr_ptr=0 after release.
